// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the load/store sequencer: op codes, FSM states, store-merge selects.
package mem_access_pkg;

    typedef logic [2:0] op_t;
    typedef logic [2:0] state_t;
    typedef logic [1:0] wr_sel_t;

    localparam op_t OP_LW = 3'd0;
    localparam op_t OP_LH = 3'd1;
    localparam op_t OP_LB = 3'd2;
    localparam op_t OP_SW = 3'd3;
    localparam op_t OP_SH = 3'd4;
    localparam op_t OP_SB = 3'd5;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RD    = 3'd1;
    localparam state_t ST_LATCH = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam wr_sel_t WR_WORD = 2'd0;
    localparam wr_sel_t WR_HALF = 2'd1;
    localparam wr_sel_t WR_BYTE = 2'd2;

    // Partial stores need the old word first, so they take the read path.
    function automatic logic is_rmw(op_t op);
        return (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Control-unit / memory-side signal bundle of the load/store sequencer.
interface mem_access_ctrl_if;
    import mem_access_pkg::*;

    logic        start;
    op_t         op;
    logic [31:0] addr;
    logic [31:0] mdr_q;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic        mdr_load;
    wr_sel_t     wr_sel;
    logic [31:0] load_data;
    logic        busy;
    logic        done;
    logic        fault;

    modport master (
        output start, op, addr, mdr_q,
        input  mem_addr, mem_rd, mem_wr, mdr_load, wr_sel, load_data, busy, done, fault
    );

    modport slave (
        input  start, op, addr, mdr_q,
        output mem_addr, mem_rd, mem_wr, mdr_load, wr_sel, load_data, busy, done, fault
    );

endinterface

// File: rtl/mem_lat_counter.sv
// Read-latency down-counter: loaded with MEM_LAT-1 on request, flags zero when the read data is due.
module mem_lat_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam logic [2:0] INIT = 3'(MEM_LAT - 1);

    logic [2:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= INIT;
        end else if (dec) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign zero = (cnt == 3'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer with read-modify-write for SH/SB.
// Optional build macro MEM_ALIGN_CHECK_EN rejects misaligned LW/SW/LH/SH with a fault pulse.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    mem_access_ctrl_if.slave bus
);

    state_t      state;
    state_t      state_next;
    op_t         op_q;
    logic [31:0] addr_q;
    logic        fault_q;
    logic        misaligned;
    logic        accept;
    logic        reject;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;

    function automatic logic [31:0] extract(op_t op, logic [31:0] w);
        case (op)
            OP_LW:   return w;
            OP_LH:   return {{16{w[15]}}, w[15:0]};
            OP_LB:   return {{24{w[7]}}, w[7:0]};
            default: return '0;
        endcase
    endfunction

    always_comb begin
        misaligned = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        case (bus.op)
            OP_LW, OP_SW: misaligned = |bus.addr[1:0];
            OP_LH, OP_SH: misaligned = bus.addr[0];
            default:      misaligned = 1'b0;
        endcase
`else
        misaligned = 1'b0;
`endif
    end

    // Requests are only looked at in IDLE; anything arriving while busy is dropped.
    assign accept = (state == ST_IDLE) && bus.start && (bus.op <= OP_SB) && !misaligned;
    assign reject = (state == ST_IDLE) && bus.start && !accept;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = (bus.op == OP_SW) ? ST_WRITE : ST_RD;
            ST_RD:    if (cnt_zero) state_next = ST_LATCH;
            ST_LATCH: state_next = is_rmw(op_q) ? ST_WRITE : ST_DONE;
            ST_WRITE: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign cnt_load = accept && (bus.op != OP_SW);
    assign cnt_dec  = (state == ST_RD) && !cnt_zero;

    mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            fault_q <= reject;
            if (accept) begin
                op_q   <= bus.op;
                addr_q <= bus.addr;
            end
        end
    end

    // Strobes decode the registered state only, so reset drops them at once.
    assign bus.mem_addr  = addr_q;
    assign bus.mem_rd    = (state == ST_RD);
    assign bus.mem_wr    = (state == ST_WRITE);
    assign bus.mdr_load  = (state == ST_LATCH);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.fault     = fault_q;
    assign bus.wr_sel    = (state != ST_WRITE) ? WR_WORD :
                           (op_q == OP_SH)     ? WR_HALF :
                           (op_q == OP_SB)     ? WR_BYTE : WR_WORD;
    assign bus.load_data = (state == ST_DONE) ? extract(op_q, bus.mdr_q) : '0;

endmodule
